// File: rtl/jzjpcc_divider_sequencer_if.sv
// Execute-stage port bundle between the pipeline (master) and the RV32M divide unit (slave).
// start_execute is a level: the divide holds execute while stall_execute is high, and
// resultValid_execute pulses for exactly one cycle, the cycle the pipeline advances.
interface jzjpcc_divider_sequencer_if;
  logic        start_execute;
  logic [1:0]  divOperation_execute;
  logic [31:0] rs1_execute;
  logic [31:0] rs2_execute;
  logic        flush_execute;
  logic        stall_execute;
  logic [31:0] result_execute;
  logic        resultValid_execute;

  modport master (
    output start_execute,
    output divOperation_execute,
    output rs1_execute,
    output rs2_execute,
    output flush_execute,
    input  stall_execute,
    input  result_execute,
    input  resultValid_execute
  );

  modport slave (
    input  start_execute,
    input  divOperation_execute,
    input  rs1_execute,
    input  rs2_execute,
    input  flush_execute,
    output stall_execute,
    output result_execute,
    output resultValid_execute
  );
endinterface

// File: rtl/jzjpcc_divider_sequencer.sv
// Iterative restoring RV32M divider (DIV/DIVU/REM/REMU) with execute-stage stall control.
// Optional macro JZJPCC_DIV_FASTPATH_EN: resolve divide-by-zero / signed overflow in one cycle.
module jzjpcc_divider_sequencer #(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                       clock,
  input  logic                       reset,
  jzjpcc_divider_sequencer_if.slave  bus,
  output logic [1:0]                 state_dbg
);

  localparam int N     = 32 / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic               sign_a_q, sign_a_d;
  logic               sign_b_q, sign_b_d;
  logic [31:0]        quo_q, quo_d;        // dividend bits shift out, quotient bits shift in
  logic [31:0]        divisor_q, divisor_d;
  logic [32:0]        rem_q, rem_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        rs1_q, rs1_d;
  logic               dz_q, dz_d;
  logic               ovf_q, ovf_d;
  logic [31:0]        result_q, result_d;
  logic               valid_q, valid_d;

  // Operand decode for the cycle a divide arrives in IDLE.
  logic        in_signed;
  logic        in_sign_a;
  logic        in_sign_b;
  logic [31:0] in_abs_a;
  logic [31:0] in_abs_b;
  logic        in_dz;
  logic        in_ovf;

  always_comb begin
    in_signed = ~bus.divOperation_execute[0];
    in_sign_a = in_signed & bus.rs1_execute[31];
    in_sign_b = in_signed & bus.rs2_execute[31];
    in_abs_a  = in_sign_a ? (~bus.rs1_execute + 32'd1) : bus.rs1_execute;
    in_abs_b  = in_sign_b ? (~bus.rs2_execute + 32'd1) : bus.rs2_execute;
    in_dz     = (bus.rs2_execute == 32'd0);
    in_ovf    = in_signed & (bus.rs1_execute == 32'h8000_0000) &
                (bus.rs2_execute == 32'hFFFF_FFFF);
  end

  // One iteration cycle: BITS_PER_CYCLE restoring steps chained combinationally.
  // The trial difference carries an extra bit so a shifted remainder >= 2^32 is not
  // mistaken for a borrow.
  logic [32:0] it_rem;
  logic [31:0] it_quo;
  logic [33:0] it_diff;

  always_comb begin
    it_rem  = rem_q;
    it_quo  = quo_q;
    it_diff = '0;
    for (int b = 0; b < BITS_PER_CYCLE; b++) begin
      it_rem  = {it_rem[31:0], it_quo[31]};
      it_quo  = {it_quo[30:0], 1'b0};
      it_diff = {1'b0, it_rem} - {2'b00, divisor_q};
      if (!it_diff[33]) begin
        it_rem    = it_diff[32:0];
        it_quo[0] = 1'b1;
      end
    end
  end

  // Sign correction and special-case overrides applied to the raw magnitudes.
  logic        fix_neg_q;
  logic [31:0] fix_quo;
  logic [31:0] fix_rem;
  logic [31:0] fix_result;

  always_comb begin
    fix_neg_q = ~op_q[0] & (sign_a_q ^ sign_b_q);
    fix_quo   = fix_neg_q ? (~quo_q + 32'd1) : quo_q;
    fix_rem   = sign_a_q ? (~rem_q[31:0] + 32'd1) : rem_q[31:0];
    if (dz_q) begin
      fix_quo = 32'hFFFF_FFFF;
      fix_rem = rs1_q;
    end else if (ovf_q) begin
      fix_quo = 32'h8000_0000;
      fix_rem = 32'd0;
    end
    fix_result = op_q[1] ? fix_rem : fix_quo;
  end

`ifdef JZJPCC_DIV_FASTPATH_EN
  logic        fp_special;
  logic [31:0] fp_result;

  always_comb begin
    fp_special = in_dz | in_ovf;
    if (bus.divOperation_execute[1]) begin
      fp_result = in_dz ? bus.rs1_execute : 32'd0;
    end else begin
      fp_result = in_dz ? 32'hFFFF_FFFF : 32'h8000_0000;
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    sign_a_d  = sign_a_q;
    sign_b_d  = sign_b_q;
    quo_d     = quo_q;
    divisor_d = divisor_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    rs1_d     = rs1_q;
    dz_d      = dz_q;
    ovf_d     = ovf_q;
    result_d  = result_q;
    valid_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start_execute) begin
          op_d      = bus.divOperation_execute;
          sign_a_d  = in_sign_a;
          sign_b_d  = in_sign_b;
          quo_d     = in_abs_a;
          divisor_d = in_abs_b;
          rem_d     = '0;
          cnt_d     = '0;
          rs1_d     = bus.rs1_execute;
          dz_d      = in_dz;
          ovf_d     = in_ovf;
          state_d   = ITER;
`ifdef JZJPCC_DIV_FASTPATH_EN
          if (fp_special) begin
            state_d  = DONE;
            result_d = fp_result;
            valid_d  = 1'b1;
          end
`endif
        end
      end
      ITER: begin
        rem_d = it_rem;
        quo_d = it_quo;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(N - 1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        result_d = fix_result;
        valid_d  = 1'b1;
        state_d  = DONE;
      end
      DONE: begin
        // start_execute is still the retiring instruction here; it is not a new request.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // An aborted divide leaves result_execute untouched and never raises valid.
    if (bus.flush_execute) begin
      state_d  = IDLE;
      valid_d  = 1'b0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      op_q      <= '0;
      sign_a_q  <= 1'b0;
      sign_b_q  <= 1'b0;
      quo_q     <= '0;
      divisor_q <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      rs1_q     <= '0;
      dz_q      <= 1'b0;
      ovf_q     <= 1'b0;
      result_q  <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      sign_a_q  <= sign_a_d;
      sign_b_q  <= sign_b_d;
      quo_q     <= quo_d;
      divisor_q <= divisor_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
      rs1_q     <= rs1_d;
      dz_q      <= dz_d;
      ovf_q     <= ovf_d;
      result_q  <= result_d;
      valid_q   <= valid_d;
    end
  end

  // Stall must rise in the arrival cycle, so it is decoded from state plus live inputs.
  assign bus.stall_execute = reset & ~bus.flush_execute &
                             (((state_q == IDLE) & bus.start_execute) |
                              (state_q == ITER) | (state_q == FIX));
  assign bus.result_execute      = result_q;
  assign bus.resultValid_execute = valid_q;
  assign state_dbg               = state_q;

endmodule

// File: tb/tb_jzjpcc_divider_sequencer.sv
// Directed bench for jzjpcc_divider_sequencer: signed/unsigned results, special cases,
// latency and stall length, flush abort and asynchronous reset mid-operation.
module tb_jzjpcc_divider_sequencer;

  localparam int N         = 32;
  localparam int LAT_FULL  = N + 2;
`ifdef JZJPCC_DIV_FASTPATH_EN
  localparam int LAT_SPEC  = 1;
`else
  localparam int LAT_SPEC  = LAT_FULL;
`endif

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  state_dbg;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_result = 32'd0;

  jzjpcc_divider_sequencer_if dif();

  jzjpcc_divider_sequencer #(.BITS_PER_CYCLE(1)) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (dif),
    .state_dbg (state_dbg)
  );

  // Clock / reset
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives one divide from c0 through DONE, then drops start in the following IDLE cycle.
  task automatic run_div(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int lat);
    int          cyc;
    int          stall_cnt;
    bit          seen;
    logic [31:0] e;
    exp_q.push_back(exp);
    @(negedge clock);
    dif.start_execute        = 1'b1;
    dif.divOperation_execute = op;
    dif.rs1_execute          = a;
    dif.rs2_execute          = b;
    #1;
    check_eq({tag, "_stall_c0"}, 32'(dif.stall_execute), 32'd1);
    cyc       = 0;
    stall_cnt = 1;
    seen      = 1'b0;
    while (!seen && cyc < 200) begin
      @(negedge clock);
      cyc++;
      if (dif.resultValid_execute) seen = 1'b1;
      else if (dif.stall_execute) stall_cnt++;
    end
    check_eq({tag, "_latency"}, 32'(cyc), 32'(lat));
    check_eq({tag, "_stall_cycles"}, 32'(stall_cnt), 32'(lat));
    e = exp_q.pop_front();
    check_eq({tag, "_result"}, dif.result_execute, e);
    check_eq({tag, "_stall_done"}, 32'(dif.stall_execute), 32'd0);
    last_result = e;
    @(negedge clock);
    dif.start_execute = 1'b0;
    #1;
    check_eq({tag, "_idle_after"}, 32'({dif.resultValid_execute, state_dbg}), 32'd0);
  endtask

  initial begin
    bit saw_valid;
    dif.start_execute        = 1'b0;
    dif.divOperation_execute = 2'b00;
    dif.rs1_execute          = 32'd0;
    dif.rs2_execute          = 32'd0;
    dif.flush_execute        = 1'b0;

    // Reset state, including stall gated off while start is high during reset
    #2;
    dif.start_execute = 1'b1;
    #1;
    check_eq("reset_stall", 32'(dif.stall_execute), 32'd0);
    check_eq("reset_valid", 32'(dif.resultValid_execute), 32'd0);
    check_eq("reset_result", dif.result_execute, 32'd0);
    check_eq("reset_state", 32'(state_dbg), 32'd0);
    dif.start_execute = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check_eq("idle_no_stall", 32'(dif.stall_execute), 32'd0);

    run_div("div_100_7",      OP_DIV,  32'd100,       32'd7,          32'd14,         LAT_FULL);
    run_div("rem_m100_7",     OP_REM,  32'hFFFF_FF9C, 32'd7,          32'hFFFF_FFFE,  LAT_FULL);
    run_div("div_m100_7",     OP_DIV,  32'hFFFF_FF9C, 32'd7,          32'hFFFF_FFF2,  LAT_FULL);
    run_div("div_100_m7",     OP_DIV,  32'd100,       32'hFFFF_FFF9,  32'hFFFF_FFF2,  LAT_FULL);
    run_div("rem_100_m7",     OP_REM,  32'd100,       32'hFFFF_FFF9,  32'd2,          LAT_FULL);
    run_div("divu_max_16",    OP_DIVU, 32'hFFFF_FFFF, 32'h10,         32'h0FFF_FFFF,  LAT_FULL);
    run_div("remu_max_16",    OP_REMU, 32'hFFFF_FFFF, 32'h10,         32'h0000_000F,  LAT_FULL);
    run_div("divu_7_9",       OP_DIVU, 32'd7,         32'd9,          32'd0,          LAT_FULL);
    run_div("remu_7_9",       OP_REMU, 32'd7,         32'd9,          32'd7,          LAT_FULL);
    run_div("divu_by_zero",   OP_DIVU, 32'h1234_5678, 32'd0,          32'hFFFF_FFFF,  LAT_SPEC);
    run_div("remu_by_zero",   OP_REMU, 32'h1234_5678, 32'd0,          32'h1234_5678,  LAT_SPEC);
    run_div("div_m1_by_zero", OP_DIV,  32'hFFFF_FFFF, 32'd0,          32'hFFFF_FFFF,  LAT_SPEC);
    run_div("rem_m1_by_zero", OP_REM,  32'hFFFF_FFFF, 32'd0,          32'hFFFF_FFFF,  LAT_SPEC);
    run_div("div_overflow",   OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF,  32'h8000_0000,  LAT_SPEC);
    run_div("rem_overflow",   OP_REM,  32'h8000_0000, 32'hFFFF_FFFF,  32'd0,          LAT_SPEC);
    run_div("divu_min_m1",    OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF,  32'd0,          LAT_FULL);

    // Flush at c10 of DIVU 1000/3
    @(negedge clock);
    dif.start_execute        = 1'b1;
    dif.divOperation_execute = OP_DIVU;
    dif.rs1_execute          = 32'd1000;
    dif.rs2_execute          = 32'd3;
    repeat (10) @(negedge clock);
    dif.flush_execute = 1'b1;
    #1;
    check_eq("flush_stall_c10", 32'(dif.stall_execute), 32'd0);
    @(negedge clock);
    dif.flush_execute = 1'b0;
    dif.start_execute = 1'b0;
    #1;
    check_eq("flush_state_c11", 32'(state_dbg), 32'd0);
    check_eq("flush_result_kept", dif.result_execute, last_result);
    saw_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (dif.resultValid_execute) saw_valid = 1'b1;
    end
    check_eq("flush_no_valid", 32'(saw_valid), 32'd0);
    check_eq("flush_result_late", dif.result_execute, last_result);
    run_div("divu_9_3_post_flush", OP_DIVU, 32'd9, 32'd3, 32'd3, LAT_FULL);

    // Asynchronous reset at c5 of an active divide
    @(negedge clock);
    dif.start_execute        = 1'b1;
    dif.divOperation_execute = OP_DIVU;
    dif.rs1_execute          = 32'd1000;
    dif.rs2_execute          = 32'd3;
    repeat (5) @(negedge clock);
    check_eq("pre_reset_stall", 32'(dif.stall_execute), 32'd1);
    reset = 1'b0;
    #1;
    check_eq("midop_reset_stall", 32'(dif.stall_execute), 32'd0);
    check_eq("midop_reset_valid", 32'(dif.resultValid_execute), 32'd0);
    check_eq("midop_reset_result", dif.result_execute, 32'd0);
    check_eq("midop_reset_state", 32'(state_dbg), 32'd0);
    dif.start_execute = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    last_result = 32'd0;
    run_div("divu_9_3_post_reset", OP_DIVU, 32'd9, 32'd3, 32'd3, LAT_FULL);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
